// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-op sequencer.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
package lm_sm_sequencer_pkg;

    // One mask bit per architectural register R0..R7.
    localparam int LMSM_MASK_W = 8;

    // Major opcodes carried in IR[15:12].
    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // True for the two multi-register transfer opcodes.
    function automatic logic is_lmsm(input logic [3:0] opc);
        return (opc == OPC_LM) || (opc == OPC_SM);
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_lowest_set_bit_enc.sv
// Priority encoder: index of the lowest set mask bit, any-set flag, exactly-one-set flag.
// Latency: purely combinational.
// Backpressure: none.
module lowest_set_bit_enc
    import lm_sm_sequencer_pkg::*;
#(
    parameter int W  = LMSM_MASK_W,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          vld_o,
    output logic          single_o
);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    always_comb begin
        vld_o    = |mask_i;
        single_o = vld_o & ~(|(mask_i & (mask_i - W'(1))));
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: expands one load/store-multiple into one single-register micro-op per cycle.
// Latency: first micro-op in the cycle after start; done pulses the cycle after the last micro-op.
// Backpressure: stall_in freezes all state and outputs; busy holds the front end until the last advance.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int MASK_W = LMSM_MASK_W,
    parameter int OFFS_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ir,
    input  logic              start,
    input  logic              stall_in,
    input  logic              flush,
    output logic              busy,
    output logic              uop_valid,
    output logic [2:0]        uop_reg,
    output logic [2:0]        uop_base,
    output logic [OFFS_W-1:0] uop_offset,
    output logic              uop_is_load,
    output logic              uop_last,
    output logic              uop_wr_r7,
    output logic              done
);

    state_e              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [2:0]          base_q, base_d;
    logic                load_q, load_d;
    logic [OFFS_W-1:0]   offs_q, offs_d;
    logic                done_q, done_d;

    logic [2:0]          enc_idx;
    logic                enc_vld;
    logic                enc_single;

    logic [MASK_W-1:0]   ir_mask;
    logic                ir_lmsm;
    logic                ir_multi;
    logic                unused_ir_bit;

    assign ir_mask       = ir[MASK_W-1:0];
    assign ir_lmsm       = is_lmsm(ir[15:12]);
    // More than one bit set in the incoming mask.
    assign ir_multi      = |(ir_mask & (ir_mask - MASK_W'(1)));
    // IR[8] is not part of the LM/SM encoding.
    assign unused_ir_bit = ir[8];

    lowest_set_bit_enc #(
        .W  (MASK_W),
        .IW (3)
    ) u_enc (
        .mask_i   (mask_q),
        .idx_o    (enc_idx),
        .vld_o    (enc_vld),
        .single_o (enc_single)
    );

    // State register: all sequencer state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            base_q  <= '0;
            load_q  <= 1'b0;
            offs_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            base_q  <= base_d;
            load_q  <= load_d;
            offs_q  <= offs_d;
            done_q  <= done_d;
        end
    end

    // Next state: accept in IDLE, retire one mask bit per unstalled RUN cycle; flush beats stall.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        base_d  = base_q;
        load_d  = load_q;
        offs_d  = offs_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && ir_lmsm && !flush) begin
                    mask_d = ir_mask;
                    base_d = ir[11:9];
                    load_d = (ir[15:12] == OPC_LM);
                    offs_d = '0;
                    if (ir_mask != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        // Empty mask retires at once without issuing anything.
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                end else if (!stall_in) begin
                    mask_d = mask_q & (mask_q - MASK_W'(1));
                    offs_d = offs_q + OFFS_W'(1);
                    if (enc_single) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: micro-op fields straight from registers; busy also looks at the incoming instruction.
    always_comb begin
        uop_valid   = (state_q == ST_RUN) & enc_vld;
        uop_reg     = (state_q == ST_RUN) ? enc_idx : 3'd0;
        uop_base    = base_q;
        uop_offset  = offs_q;
        uop_is_load = load_q;
        uop_last    = (state_q == ST_RUN) & enc_single;
        uop_wr_r7   = (state_q == ST_RUN) & load_q & (&enc_idx);
        done        = done_q;
        busy        = ((state_q == ST_RUN) & ~(enc_single & ~stall_in))
                    | ((state_q == ST_IDLE) & start & ir_lmsm & ir_multi);
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for the LM/SM sequencer with a scoreboard of expected micro-ops and done pulses.
// Latency: expected cycle numbers are carried with each scoreboard entry.
// Backpressure: stalled micro-ops are re-checked every held cycle and retired on the advancing one.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = '0;
    logic        start = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        uop_valid;
    logic [2:0]  uop_reg;
    logic [2:0]  uop_base;
    logic [15:0] uop_offset;
    logic        uop_is_load;
    logic        uop_last;
    logic        uop_wr_r7;
    logic        done;

    typedef struct {
        bit          is_done;
        logic [2:0]  r;
        logic [2:0]  base;
        logic [15:0] offs;
        bit          ld;
        bit          last;
        bit          wr7;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    lm_sm_sequencer #(.MASK_W(8), .OFFS_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .ir          (ir),
        .start       (start),
        .stall_in    (stall_in),
        .flush       (flush),
        .busy        (busy),
        .uop_valid   (uop_valid),
        .uop_reg     (uop_reg),
        .uop_base    (uop_base),
        .uop_offset  (uop_offset),
        .uop_is_load (uop_is_load),
        .uop_last    (uop_last),
        .uop_wr_r7   (uop_wr_r7),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_uop(input logic [2:0] r, input logic [2:0] base, input int offs,
                            input bit ld, input bit last, input bit wr7, input int c);
        exp_t e;
        e.is_done = 1'b0; e.r = r; e.base = base; e.offs = 16'(offs);
        e.ld = ld; e.last = last; e.wr7 = wr7; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_done(input int c);
        exp_t e;
        e.is_done = 1'b1; e.r = '0; e.base = '0; e.offs = '0;
        e.ld = 1'b0; e.last = 1'b0; e.wr7 = 1'b0; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   busy,        0);
        chk({tag, "_valid"},  uop_valid,   0);
        chk({tag, "_reg"},    uop_reg,     0);
        chk({tag, "_base"},   uop_base,    0);
        chk({tag, "_offset"}, uop_offset,  0);
        chk({tag, "_load"},   uop_is_load, 0);
        chk({tag, "_last"},   uop_last,    0);
        chk({tag, "_wr_r7"},  uop_wr_r7,   0);
        chk({tag, "_done"},   done,        0);
    endtask

    // Monitor: checks every presented done / micro-op against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                chk("done_expected", (sb.size() > 0) ? 32'(sb[0].is_done) : 32'd0, 1);
                if (sb.size() > 0 && sb[0].is_done) begin
                    chk("done_cycle", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
            if (uop_valid) begin
                chk("uop_expected", (sb.size() > 0) ? 32'(!sb[0].is_done) : 32'd0, 1);
                if (sb.size() > 0 && !sb[0].is_done) begin
                    chk("uop_reg",     uop_reg,     sb[0].r);
                    chk("uop_base",    uop_base,    sb[0].base);
                    chk("uop_offset",  uop_offset,  sb[0].offs);
                    chk("uop_is_load", uop_is_load, sb[0].ld);
                    chk("uop_last",    uop_last,    sb[0].last);
                    chk("uop_wr_r7",   uop_wr_r7,   sb[0].wr7);
                    if (!stall_in || flush) begin
                        chk("uop_cycle", cyc, sb[0].cyc);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int c;
        // Reset state
        #1 reset = 1'b0;
        #1 chk_all_zero("reset");
        tick(2);
        reset = 1'b1;
        tick(1);

        // LM base R2, mask 1010_0101: R0,R2,R5,R7 then done
        c = cyc;
        ir = {4'b0110, 3'd2, 1'b0, 8'hA5}; start = 1'b1;
        #1 chk("lm_busy_accept", busy, 1);
        push_uop(3'd0, 3'd2, 0, 1, 0, 0, c + 1);
        push_uop(3'd2, 3'd2, 1, 1, 0, 0, c + 2);
        push_uop(3'd5, 3'd2, 2, 1, 0, 0, c + 3);
        push_uop(3'd7, 3'd2, 3, 1, 1, 1, c + 4);
        push_done(c + 5);
        tick(1);
        start = 1'b0;
        #1 chk("lm_busy_run", busy, 1);
        tick(3);
        chk("lm_busy_last", busy, 0);
        tick(3);

        // SM with empty mask: no micro-op, done next cycle, never busy
        c = cyc;
        ir = {4'b0111, 3'd1, 1'b0, 8'h00}; start = 1'b1;
        #1 chk("sm0_busy_accept", busy, 0);
        push_done(c + 1);
        tick(1);
        start = 1'b0;
        #1 chk("sm0_busy_after", busy, 0);
        chk("sm0_no_valid", uop_valid, 0);
        tick(3);

        // SM single register R4, three stall cycles
        c = cyc;
        ir = {4'b0111, 3'd3, 1'b0, 8'h10}; start = 1'b1;
        push_uop(3'd4, 3'd3, 0, 0, 1, 0, c + 4);
        push_done(c + 5);
        tick(1);
        start = 1'b0; stall_in = 1'b1;
        #1 chk("sm1_busy_stalled", busy, 1);
        tick(3);
        stall_in = 1'b0;
        #1 chk("sm1_busy_release", busy, 0);
        tick(3);

        // LM mask FF flushed on the third micro-op, then LM mask 01
        c = cyc;
        ir = {4'b0110, 3'd0, 1'b0, 8'hFF}; start = 1'b1;
        push_uop(3'd0, 3'd0, 0, 1, 0, 0, c + 1);
        push_uop(3'd1, 3'd0, 1, 1, 0, 0, c + 2);
        push_uop(3'd2, 3'd0, 2, 1, 0, 0, c + 3);
        tick(1);
        start = 1'b0;
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        #1 chk("flush_busy", busy, 0);
        chk("flush_valid", uop_valid, 0);
        c = cyc;
        ir = {4'b0110, 3'd5, 1'b0, 8'h01}; start = 1'b1;
        #1 chk("lm1_busy_accept", busy, 0);
        push_uop(3'd0, 3'd5, 0, 1, 1, 0, c + 1);
        push_done(c + 2);
        tick(1);
        start = 1'b0;
        tick(3);

        // Async reset in the middle of LM mask F0, then clean restart
        c = cyc;
        ir = {4'b0110, 3'd4, 1'b0, 8'hF0}; start = 1'b1;
        push_uop(3'd4, 3'd4, 0, 1, 0, 0, c + 1);
        push_uop(3'd5, 3'd4, 1, 1, 0, 0, c + 2);
        tick(1);
        start = 1'b0;
        tick(1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_all_zero("midreset");
        tick(1);
        reset = 1'b1;
        tick(1);
        c = cyc;
        ir = {4'b0111, 3'd6, 1'b0, 8'h82}; start = 1'b1;
        #1 chk("restart_busy", busy, 1);
        push_uop(3'd1, 3'd6, 0, 0, 0, 0, c + 1);
        push_uop(3'd7, 3'd6, 1, 0, 1, 0, c + 2);
        push_done(c + 3);
        tick(1);
        start = 1'b0;
        tick(4);

        // Non-LM/SM opcode is ignored
        ir = 16'h0A3F; start = 1'b1;
        #1 chk("add_busy", busy, 0);
        tick(1);
        start = 1'b0;
        #1 chk("add_valid", uop_valid, 0);
        chk("add_done", done, 0);
        tick(3);

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
